// File: rtl/tx_packet_framer_pkg.sv
// Shared framing constants and symbol helpers for the transmit packet framer.
package tx_framing_pkg;

  localparam int BEAT_BYTES  = 64;
  localparam int ACC_BYTES   = 128;
  localparam int FRAME_BYTES = BEAT_BYTES + 2;   // start + data + end
  localparam int BEAT_BITS   = BEAT_BYTES * 8;
  localparam int ACC_BITS    = ACC_BYTES * 8;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;

  // 8b/10b framing K-symbols and logical idle
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] IDL = 8'h00;

  function automatic logic [7:0] start_sym(input logic dllp);
    return dllp ? SDP : STP;
  endfunction

  // Only TLPs can be nullified; DLLPs always close with END.
  function automatic logic [7:0] end_sym(input logic dllp, input logic nullify);
    return (!dllp && nullify) ? EDB : END;
  endfunction

endpackage

// File: rtl/tx_packet_framer_if.sv
// Byte-stream input and framed-beat output of the transmit packet framer.
//
// Handshake: the source holds in_valid and all in_* fields stable until the
// cycle in which in_valid && in_ready are both 1; that cycle transfers the
// beat. in_ready never depends on in_valid. The output side has no
// back-pressure: a beat is presented for exactly the cycle valid_out is 1.
interface tx_packet_framer_if;
  import tx_framing_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [BEAT_BITS-1:0]  in_data;
  logic [6:0]            in_bytes;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_dllp;
  logic                  in_nullify;
  logic [BEAT_BITS-1:0]  data_out;
  logic [BEAT_BYTES-1:0] DK;
  logic                  valid_out;

  modport master (
    output in_valid, in_data, in_bytes, in_sop, in_eop, in_dllp, in_nullify,
    input  in_ready, data_out, DK, valid_out
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_sop, in_eop, in_dllp, in_nullify,
    output in_ready, data_out, DK, valid_out
  );

endinterface

// File: rtl/tx_packet_framer_byte_placer.sv
// Combinational barrel placer: writes frame_n bytes of a framed vector into
// the accumulator starting at byte offset, leaving all other bytes untouched.
module tx_byte_placer
  import tx_framing_pkg::*;
(
  input  logic [ACC_BITS-1:0]    base_data,
  input  logic [ACC_BYTES-1:0]   base_k,
  input  logic [7:0]             offset,
  input  logic [FRAME_BITS-1:0]  frame_data,
  input  logic [FRAME_BYTES-1:0] frame_k,
  input  logic [6:0]             frame_n,
  output logic [ACC_BITS-1:0]    acc_data,
  output logic [ACC_BYTES-1:0]   acc_k
);

  logic [ACC_BYTES-1:0] byte_mask;
  logic [ACC_BITS-1:0]  bit_mask;
  logic [ACC_BITS-1:0]  shifted_data;
  logic [ACC_BYTES-1:0] shifted_k;

  // Shift the frame into position and merge it under a per-byte write mask
  always_comb begin
    byte_mask = (~({ACC_BYTES{1'b1}} << frame_n)) << offset;
    bit_mask  = '0;
    for (int i = 0; i < ACC_BYTES; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    end
    shifted_data = {{(ACC_BITS-FRAME_BITS){1'b0}}, frame_data} << {offset, 3'b000};
    shifted_k    = {{(ACC_BYTES-FRAME_BYTES){1'b0}}, frame_k} << offset;
    acc_data     = (base_data & ~bit_mask) | (shifted_data & bit_mask);
    acc_k        = (base_k & ~byte_mask) | (shifted_k & byte_mask);
  end

endmodule

// File: rtl/tx_packet_framer.sv
// Transmit packet framer: wraps TLP/DLLP byte streams in STP/SDP .. END/EDB
// K-symbols and packs them contiguously into 64-byte beats for the PHY.
module tx_packet_framer
  import tx_framing_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                linkup,
  tx_packet_framer_if.slave   bus,
  output logic                err_protocol
);

  // Accumulator invariant: every byte at index >= fill is idle with K=0.
  logic [ACC_BITS-1:0]    acc_data;
  logic [ACC_BYTES-1:0]   acc_k;
  logic [7:0]             fill;
  logic                   pkt_open;
  logic                   pkt_dllp;

  logic                   emit_valid;
  logic [BEAT_BITS-1:0]   emit_data;
  logic [BEAT_BYTES-1:0]  emit_k;
  logic [ACC_BITS-1:0]    base_data;
  logic [ACC_BYTES-1:0]   base_k;
  logic [7:0]             fill_after;

  logic                   accept, bad_len, drop, have_start, place, cur_dllp;
  logic [6:0]             end_pos, frame_n, place_n;
  logic [BEAT_BITS-1:0]   keep_mask;
  logic [FRAME_BITS-1:0]  frame_data;
  logic [FRAME_BYTES-1:0] frame_k;
  logic [ACC_BITS-1:0]    placed_data;
  logic [ACC_BYTES-1:0]   placed_k;

  logic [BEAT_BITS-1:0]   data_out_q;
  logic [BEAT_BYTES-1:0]  dk_q;
  logic                   valid_out_q;

  // Emit step: full beat, idle-padded flush between packets, or underrun bubble
  always_comb begin
    emit_valid = 1'b0;
    emit_data  = '0;
    emit_k     = '0;
    base_data  = acc_data;
    base_k     = acc_k;
    fill_after = fill;
    if (fill >= 8'd64) begin
      emit_valid = 1'b1;
      emit_data  = acc_data[BEAT_BITS-1:0];
      emit_k     = acc_k[BEAT_BYTES-1:0];
      base_data  = {{BEAT_BITS{1'b0}}, acc_data[ACC_BITS-1:BEAT_BITS]};
      base_k     = {{BEAT_BYTES{1'b0}}, acc_k[ACC_BYTES-1:BEAT_BYTES]};
      fill_after = fill - 8'd64;
    end else if (!pkt_open) begin
      emit_valid = 1'b1;
      emit_data  = acc_data[BEAT_BITS-1:0];
      emit_k     = acc_k[BEAT_BYTES-1:0];
      base_data  = '0;
      base_k     = '0;
      fill_after = 8'd0;
    end
  end

  // A closed accumulator must also leave room for the start symbol
  assign bus.in_ready = !rst && linkup &&
                        (pkt_open ? (fill_after <= 8'd63) : (fill_after <= 8'd62));

  assign accept     = bus.in_valid && bus.in_ready;
  assign bad_len    = (bus.in_bytes == 7'd0) || (bus.in_bytes > 7'd64);
  assign drop       = bad_len || (!bus.in_sop && !pkt_open);
  assign have_start = bus.in_sop && !pkt_open;
  assign place      = accept && !drop;
  assign cur_dllp   = have_start ? bus.in_dllp : pkt_dllp;
  assign end_pos    = {6'b0, have_start} + bus.in_bytes;
  assign frame_n    = end_pos + {6'b0, bus.in_eop};
  assign place_n    = place ? frame_n : 7'd0;
  assign keep_mask  = ~({BEAT_BITS{1'b1}} << {bus.in_bytes, 3'b000});

  // Build the framed vector: [start] data[0..in_bytes-1] [end]
  always_comb begin
    frame_data = {16'b0, bus.in_data & keep_mask} << {have_start, 3'b000};
    frame_k    = {{(FRAME_BYTES-1){1'b0}}, have_start};
    if (have_start) begin
      frame_data[7:0] = start_sym(bus.in_dllp);
    end
    if (bus.in_eop) begin
      frame_data = frame_data |
                   ({{(FRAME_BITS-8){1'b0}}, end_sym(cur_dllp, bus.in_nullify)}
                    << {end_pos, 3'b000});
      frame_k    = frame_k | ({{(FRAME_BYTES-1){1'b0}}, 1'b1} << end_pos);
    end
  end

  tx_byte_placer u_placer (
    .base_data  (base_data),
    .base_k     (base_k),
    .offset     (fill_after),
    .frame_data (frame_data),
    .frame_k    (frame_k),
    .frame_n    (place_n),
    .acc_data   (placed_data),
    .acc_k      (placed_k)
  );

  // Accumulator, fill, packet-open tracking and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data     <= '0;
      acc_k        <= '0;
      fill         <= 8'd0;
      pkt_open     <= 1'b0;
      pkt_dllp     <= 1'b0;
      err_protocol <= 1'b0;
    end else if (!linkup) begin
      acc_data     <= '0;
      acc_k        <= '0;
      fill         <= 8'd0;
      pkt_open     <= 1'b0;
      pkt_dllp     <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      acc_data <= placed_data;
      acc_k    <= placed_k;
      fill     <= fill_after + {1'b0, place_n};
      if (place && have_start) pkt_dllp <= bus.in_dllp;
      if (place) begin
        if (bus.in_eop)      pkt_open <= 1'b0;
        else if (bus.in_sop) pkt_open <= 1'b1;
      end
      if (accept && (drop || (bus.in_sop && pkt_open))) err_protocol <= 1'b1;
    end
  end

  // Registered output beat toward the lane striper
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      dk_q        <= '0;
      valid_out_q <= 1'b0;
    end else if (!linkup) begin
      data_out_q  <= '0;
      dk_q        <= '0;
      valid_out_q <= 1'b0;
    end else begin
      data_out_q  <= emit_data;
      dk_q        <= emit_k;
      valid_out_q <= emit_valid;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.DK        = dk_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Directed bench for tx_packet_framer: framing of TLP/DLLP packets, multi-beat
// packing, back-to-back stall behaviour, underrun bubbles, errors, link drop.
module tb_tx_packet_framer;
  import tx_framing_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic linkup;
  logic err_protocol;

  tx_packet_framer_if bus();

  tx_packet_framer dut (
    .clk          (clk),
    .rst          (rst),
    .linkup       (linkup),
    .bus          (bus),
    .err_protocol (err_protocol)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_d;
  logic [63:0]  exp_k;
  logic [8:0]   exp_q[$];   // {K, byte} expected output byte stream

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sop, input logic eop, input logic dllp,
                       input logic nul, input logic [6:0] nb, input logic [511:0] d);
    bus.in_valid   = 1'b1;
    bus.in_sop     = sop;
    bus.in_eop     = eop;
    bus.in_dllp    = dllp;
    bus.in_nullify = nul;
    bus.in_bytes   = nb;
    bus.in_data    = d;
  endtask

  task automatic idle_in();
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_dllp    = 1'b0;
    bus.in_nullify = 1'b0;
    bus.in_bytes   = 7'd0;
    bus.in_data    = '0;
  endtask

  // Bytes below n count up from base; bytes above carry junk that must not leak
  function automatic logic [511:0] pat(input logic [7:0] base, input int n);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[i*8 +: 8] = (i < n) ? 8'(base + 8'(i)) : 8'h55;
    return v;
  endfunction

  task automatic exp_idle();
    exp_d = '0;
    exp_k = '0;
  endtask

  task automatic put(input int idx, input logic [7:0] v, input logic k);
    exp_d[idx*8 +: 8] = v;
    exp_k[idx]        = k;
  endtask

  // Checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag);
    checks++;
    assert (bus.data_out === exp_d) else begin
      errors++;
      $error("FAIL %s data: observed %h expected %h", tag, bus.data_out, exp_d);
    end
    checks++;
    assert (bus.DK === exp_k) else begin
      errors++;
      $error("FAIL %s DK: observed %h expected %h", tag, bus.DK, exp_k);
    end
  endtask

  // Scoreboard: build the next expected beat from the byte queue, idle when empty
  task automatic mon_beat(input string tag);
    logic [8:0] e;
    exp_idle();
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        put(i, e[7:0], e[8]);
      end
    end
    chk1({tag, " valid"}, bus.valid_out, 1'b1);
    chk_beat(tag);
  endtask

  int stalls;
  int stall_pkt;

  initial begin
    // Reset behaviour, with linkup already high
    rst = 1'b1;
    linkup = 1'b1;
    idle_in();
    #12;
    exp_idle();
    chk1("rst valid_out", bus.valid_out, 1'b0);
    chk_beat("rst beat");
    chk1("rst err", err_protocol, 1'b0);
    chk1("rst in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle valid", bus.valid_out, 1'b1);
    chk_beat("idle beat");

    // Single-beat TLP, 14 bytes
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd14, pat(8'hA0, 14));
    chk1("tlp14 ready", bus.in_ready, 1'b1);
    tick();
    idle_in();
    tick();
    exp_idle();
    put(0, STP, 1'b1);
    for (int i = 0; i < 14; i++) put(i + 1, 8'hA0 + 8'(i), 1'b0);
    put(15, END, 1'b1);
    chk1("tlp14 valid", bus.valid_out, 1'b1);
    chk_beat("tlp14");

    // DLLP 6 bytes, then the same with nullify (still END)
    drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd6, pat(8'h30, 6));
    tick();
    idle_in();
    tick();
    exp_idle();
    put(0, SDP, 1'b1);
    for (int i = 0; i < 6; i++) put(i + 1, 8'h30 + 8'(i), 1'b0);
    put(7, END, 1'b1);
    chk_beat("dllp6");

    drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd6, pat(8'h40, 6));
    tick();
    idle_in();
    tick();
    exp_idle();
    put(0, SDP, 1'b1);
    for (int i = 0; i < 6; i++) put(i + 1, 8'h40 + 8'(i), 1'b0);
    put(7, END, 1'b1);
    chk_beat("dllp6 nullify");

    // 3-beat TLP 64+64+10
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd64, pat(8'h00, 64));
    chk1("3b ready a", bus.in_ready, 1'b1);
    tick();
    chk1("3b valid a", bus.valid_out, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd64, pat(8'h40, 64));
    chk1("3b ready b", bus.in_ready, 1'b1);
    tick();
    exp_idle();
    put(0, STP, 1'b1);
    for (int i = 0; i < 63; i++) put(i + 1, 8'(i), 1'b0);
    chk1("3b valid 1", bus.valid_out, 1'b1);
    chk_beat("3b beat1");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'd10, pat(8'hC0, 10));
    chk1("3b ready c", bus.in_ready, 1'b1);
    tick();
    exp_idle();
    put(0, 8'h3F, 1'b0);
    for (int i = 0; i < 63; i++) put(i + 1, 8'h40 + 8'(i), 1'b0);
    chk1("3b valid 2", bus.valid_out, 1'b1);
    chk_beat("3b beat2");
    idle_in();
    tick();
    exp_idle();
    put(0, 8'h7F, 1'b0);
    for (int i = 0; i < 10; i++) put(i + 1, 8'hC0 + 8'(i), 1'b0);
    put(11, END, 1'b1);
    chk1("3b valid 3", bus.valid_out, 1'b1);
    chk_beat("3b beat3");
    tick();
    exp_idle();
    chk1("3b valid idle", bus.valid_out, 1'b1);
    chk_beat("3b idle");

    // 33 back-to-back single-beat 64-byte TLPs
    stalls = 0;
    stall_pkt = -1;
    for (int p = 0; p < 33; p++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd64, pat(8'(p * 5), 64));
      for (int w = 0; w < 4 && !bus.in_ready; w++) begin
        stalls++;
        stall_pkt = p;
        tick();
        mon_beat("b2b");
      end
      tick();
      mon_beat("b2b");
      exp_q.push_back({1'b1, STP});
      for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 8'(p * 5 + i)});
      exp_q.push_back({1'b1, END});
    end
    idle_in();
    repeat (3) begin
      tick();
      mon_beat("b2b drain");
    end
    chk_int("b2b stall count", stalls, 1);
    chk_int("b2b stall packet", stall_pkt, 32);
    chk_int("b2b leftover bytes", exp_q.size(), 0);

    // 2-beat TLP, nullified, second beat withheld
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd64, pat(8'h80, 64));
    tick();
    idle_in();
    tick();
    exp_idle();
    put(0, STP, 1'b1);
    for (int i = 0; i < 63; i++) put(i + 1, 8'h80 + 8'(i), 1'b0);
    chk1("nul valid 1", bus.valid_out, 1'b1);
    chk_beat("nul beat1");
    exp_idle();
    tick();
    chk1("nul bubble1 valid", bus.valid_out, 1'b0);
    chk_beat("nul bubble1");
    tick();
    chk1("nul bubble2 valid", bus.valid_out, 1'b0);
    chk_beat("nul bubble2");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd5, pat(8'hE0, 5));
    chk1("nul ready", bus.in_ready, 1'b1);
    tick();
    chk1("nul bubble3 valid", bus.valid_out, 1'b0);
    idle_in();
    tick();
    exp_idle();
    put(0, 8'hBF, 1'b0);
    for (int i = 0; i < 5; i++) put(i + 1, 8'hE0 + 8'(i), 1'b0);
    put(6, EDB, 1'b1);
    chk1("nul valid 2", bus.valid_out, 1'b1);
    chk_beat("nul beat2");

    // Non-sop beat while closed: error, dropped
    chk1("pre-err flag", err_protocol, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7'd8, pat(8'h12, 8));
    chk1("nosop ready", bus.in_ready, 1'b1);
    tick();
    idle_in();
    chk1("nosop err", err_protocol, 1'b1);
    tick();
    exp_idle();
    chk1("nosop valid", bus.valid_out, 1'b1);
    chk_beat("nosop dropped");

    // Illegal lengths 0 and 65: dropped, packet does not open
    drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, pat(8'h21, 0));
    tick();
    idle_in();
    tick();
    chk1("len0 valid", bus.valid_out, 1'b1);
    chk_beat("len0 dropped");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd65, pat(8'h22, 64));
    tick();
    idle_in();
    tick();
    chk1("len65 valid", bus.valid_out, 1'b1);
    chk_beat("len65 dropped");

    // Link drop mid-packet, then re-linkup
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd64, pat(8'h01, 64));
    tick();
    idle_in();
    linkup = 1'b0;
    tick();
    chk1("linkdown valid", bus.valid_out, 1'b0);
    chk1("linkdown ready", bus.in_ready, 1'b0);
    chk1("linkdown err", err_protocol, 1'b0);
    linkup = 1'b1;
    tick();
    exp_idle();
    chk1("relink valid", bus.valid_out, 1'b1);
    chk_beat("relink idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
